// File: rtl/data_memory_be.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_be
// Purpose  : Byte-addressable data memory with byte/half/word access, sign or
//            zero extended loads, alignment/range checks and a post-reset clear
//            engine. Optional sticky store-fault flag: DMEM_FAULT_STICKY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module data_memory_be #(
  parameter int DEPTH_WORDS = 256,
  parameter int TEST_ADDR   = 0,
  parameter int TEST_W      = 16
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic [31:0]       A,
  input  logic [31:0]       WD,
  input  logic              WE,
  input  logic [1:0]        SIZE,
  input  logic              LD_SIGNED,
  output logic [31:0]       RD,
  output logic              busy,
  output logic              misalign,
  output logic              fault_sticky,
  output logic [TEST_W-1:0] test_value
);

  localparam int              c_PTR_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [c_PTR_W-1:0] c_LAST     = c_PTR_W'(DEPTH_WORDS - 1);
  localparam logic [c_PTR_W-1:0] c_TEST_IDX = c_PTR_W'(TEST_ADDR);

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_t;

  logic [31:0]        r_mem [0:DEPTH_WORDS-1];
  state_t             r_state;
  logic               r_busy;
  logic [c_PTR_W-1:0] r_ptr;

  logic               w_out_of_range;
  logic               w_misalign;
  logic               w_store;
  logic [c_PTR_W-1:0] w_idx;
  logic [31:0]        w_rword;
  logic [7:0]         w_byte;
  logic [15:0]        w_half;
  logic [31:0]        w_rd;
  logic [3:0]         w_be;
  logic [31:0]        w_wlanes;

  // Clear engine: walks every word once after reset, then parks in READY.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_state <= S_CLEAR;
      r_ptr   <= '0;
      r_busy  <= 1'b1;
    end else begin
      case (r_state)
        S_CLEAR: begin
          if (r_ptr == c_LAST) begin
            r_state <= S_READY;
            r_busy  <= 1'b0;
          end else begin
            r_ptr <= r_ptr + c_PTR_W'(1);
          end
        end
        S_READY: r_busy <= 1'b0;
        default: begin
          r_state <= S_CLEAR;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  assign w_out_of_range = ({2'b00, A[31:2]} >= 32'(DEPTH_WORDS));
  assign w_idx          = A[c_PTR_W+1:2];
  assign w_rword        = r_mem[w_idx];

  always_comb begin
    w_misalign = w_out_of_range;
    case (SIZE)
      2'b00:   w_misalign = w_out_of_range;
      2'b01:   w_misalign = w_out_of_range | A[0];
      2'b10:   w_misalign = w_out_of_range | (A[1:0] != 2'b00);
      default: w_misalign = 1'b1;
    endcase
  end

  always_comb begin
    w_byte = w_rword[7:0];
    case (A[1:0])
      2'b00:   w_byte = w_rword[7:0];
      2'b01:   w_byte = w_rword[15:8];
      2'b10:   w_byte = w_rword[23:16];
      default: w_byte = w_rword[31:24];
    endcase
    w_half = A[1] ? w_rword[31:16] : w_rword[15:0];
  end

  always_comb begin
    w_rd = '0;
    if (!r_busy && !w_misalign) begin
      case (SIZE)
        2'b00:   w_rd = {{24{LD_SIGNED & w_byte[7]}}, w_byte};
        2'b01:   w_rd = {{16{LD_SIGNED & w_half[15]}}, w_half};
        2'b10:   w_rd = w_rword;
        default: w_rd = '0;
      endcase
    end
  end

  // Store data is replicated across lanes so each byte enable picks its own copy.
  always_comb begin
    w_be     = 4'b0000;
    w_wlanes = WD;
    case (SIZE)
      2'b00: begin
        w_be     = 4'b0001 << A[1:0];
        w_wlanes = {4{WD[7:0]}};
      end
      2'b01: begin
        w_be     = A[1] ? 4'b1100 : 4'b0011;
        w_wlanes = {2{WD[15:0]}};
      end
      2'b10:   w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  assign w_store = WE & ~r_busy & ~w_misalign;

  always_ff @(posedge CLK) begin
    if (r_busy && !reset) begin
      r_mem[r_ptr] <= '0;
    end else if (w_store) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) begin
          r_mem[w_idx][8*i +: 8] <= w_wlanes[8*i +: 8];
        end
      end
    end
  end

`ifdef DMEM_FAULT_STICKY_EN
  logic r_fault;
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_fault <= 1'b0;
    end else if (WE && !r_busy && w_misalign) begin
      r_fault <= 1'b1;
    end
  end
  assign fault_sticky = r_fault;
`else
  assign fault_sticky = 1'b0;
`endif

  assign RD         = w_rd;
  assign busy       = r_busy;
  assign misalign   = w_misalign;
  assign test_value = r_busy ? '0 : r_mem[c_TEST_IDX][TEST_W-1:0];

endmodule
`default_nettype wire

// File: tb/tb_data_memory_be.sv
`default_nettype none
// Testbench for data_memory_be: directed scenarios plus randomized accesses
// compared against a byte-array reference model.
module tb_data_memory_be;

  localparam int DEPTH = 8;
  localparam int NB    = 4 * DEPTH;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A, WD;
  logic        WE;
  logic [1:0]  SIZE;
  logic        LD_SIGNED;
  logic [31:0] RD;
  logic        busy, misalign, fault_sticky;
  logic [15:0] test_value;

  int npass = 0;
  int nfail = 0;
  int ntot  = 0;

  logic [7:0] m [0:NB-1];
  bit         mfault;

  always #5 clk = ~clk;

  data_memory_be #(.DEPTH_WORDS(DEPTH), .TEST_ADDR(0), .TEST_W(16)) dut (
    .CLK(clk), .reset(reset), .A(A), .WD(WD), .WE(WE), .SIZE(SIZE),
    .LD_SIGNED(LD_SIGNED), .RD(RD), .busy(busy), .misalign(misalign),
    .fault_sticky(fault_sticky), .test_value(test_value)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit m_mis(input logic [31:0] a, input logic [1:0] sz);
    if (sz == 2'd3) return 1'b1;
    if ((a >> 2) >= DEPTH) return 1'b1;
    return (a % (32'd1 << sz)) != 0;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] a, input logic [1:0] sz, input bit sg);
    logic [31:0] v;
    int n;
    if (m_mis(a, sz)) return 32'd0;
    n = 1 << sz;
    v = 0;
    for (int k = 0; k < n; k++) v = v + (32'(m[a + k]) << (8 * k));
    if (sg && n < 4 && v[8*n-1]) v = v - (32'd1 << (8 * n));
    return v;
  endfunction

  function automatic logic [31:0] m_tv();
    return {16'd0, m[1], m[0]};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NB; i++) m[i] = 8'h00;
    mfault = 1'b0;
  endtask

  // One access cycle: check combinational outputs, then commit on the edge.
  task automatic op(input string tag, input bit we, input logic [31:0] a,
                    input logic [1:0] sz, input bit sg, input logic [31:0] wd);
    WE = we; A = a; SIZE = sz; LD_SIGNED = sg; WD = wd;
    #1;
    check({tag, ".mis"}, {31'd0, misalign}, {31'd0, m_mis(a, sz)});
    check({tag, ".rd"}, RD, m_load(a, sz, sg));
    check({tag, ".tv"}, {16'd0, test_value}, m_tv());
    check({tag, ".flt"}, {31'd0, fault_sticky}, {31'd0, mfault});
    @(posedge clk);
    if (we && !m_mis(a, sz)) begin
      for (int k = 0; k < (1 << sz); k++) m[a + k] = wd[8*k +: 8];
    end
`ifdef DMEM_FAULT_STICKY_EN
    if (we && m_mis(a, sz)) mfault = 1'b1;
`endif
    #1;
    WE = 1'b0;
  endtask

  task automatic wait_clear(input string tag, input bit try_write);
    int n;
    n = 0;
    do begin
      WE = try_write; A = 32'h0; SIZE = 2'd2; WD = 32'hDEAD_BEEF;
      #1;
      check({tag, ".tv_busy"}, {16'd0, test_value}, 32'd0);
      check({tag, ".rd_busy"}, RD, 32'd0);
      @(posedge clk);
      #1;
      n++;
    end while (busy && n < 40);
    WE = 1'b0;
    check({tag, ".edges"}, n, DEPTH);
  endtask

  initial begin
    int a;
    int sz;
    reset = 1'b1; WE = 1'b0; A = 0; WD = 0; SIZE = 2'd2; LD_SIGNED = 1'b0;
    model_clear();
    @(posedge clk); #1;
    check("rst.busy", {31'd0, busy}, 32'd1);
    check("rst.rd", RD, 32'd0);
    check("rst.tv", {16'd0, test_value}, 32'd0);
    check("rst.flt", {31'd0, fault_sticky}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    wait_clear("clr", 1'b0);
    for (int w = 0; w < DEPTH; w++) op("zero", 1'b0, 32'(4 * w), 2'd2, 1'b0, 32'd0);

    op("st_w", 1'b1, 32'h10, 2'd2, 1'b0, 32'h1122_3344);
    op("st_b", 1'b1, 32'h12, 2'd0, 1'b0, 32'h0000_00AA);
    op("st_h", 1'b1, 32'h10, 2'd1, 1'b0, 32'h0000_BEEF);
    op("ld_w", 1'b0, 32'h10, 2'd2, 1'b0, 32'd0);
    check("lanes", m_load(32'h10, 2'd2, 1'b0), 32'h11AA_BEEF);
    op("lanes_dut", 1'b0, 32'h10, 2'd2, 1'b0, 32'd0);
    A = 32'h10; SIZE = 2'd2; #1;
    check("lanes_const", RD, 32'h11AA_BEEF);

    op("st_ext", 1'b1, 32'h1C, 2'd2, 1'b0, 32'h0000_80F0);
    A = 32'h1C; SIZE = 2'd0; LD_SIGNED = 1'b1; #1;
    check("ext.bs", RD, 32'hFFFF_FFF0);
    LD_SIGNED = 1'b0; #1;
    check("ext.bu", RD, 32'h0000_00F0);
    SIZE = 2'd1; LD_SIGNED = 1'b1; #1;
    check("ext.hs", RD, 32'hFFFF_80F0);

    op("mis_h", 1'b1, 32'h1D, 2'd1, 1'b0, 32'h0000_5555);
    op("mis_w", 1'b1, 32'h1E, 2'd2, 1'b0, 32'h6666_6666);
    op("mis_r", 1'b1, 32'h1C, 2'd3, 1'b0, 32'h7777_7777);
    op("rng", 1'b1, 32'(4 * DEPTH), 2'd2, 1'b0, 32'h9999_9999);
    op("after_mis", 1'b0, 32'h1C, 2'd2, 1'b0, 32'd0);
    op("st_w0", 1'b1, 32'h0, 2'd2, 1'b0, 32'hCAFE_1234);
    op("rng2", 1'b1, 32'(4 * DEPTH + 4), 2'd2, 1'b0, 32'h0);
    op("w0", 1'b0, 32'h0, 2'd2, 1'b0, 32'd0);

    for (int i = 0; i < 80; i++) begin
      sz = int'($urandom_range(0, 3));
      a  = int'($urandom_range(0, NB + 7));
      op("rnd", 1'($urandom_range(0, 1)), 32'(a), 2'(sz), 1'($urandom_range(0, 1)), $urandom);
    end

    // Reset mid-clear, with store attempts throughout the clear.
    reset = 1'b1; #1; reset = 1'b0;
    model_clear();
    for (int i = 0; i < 3; i++) begin
      WE = 1'b1; A = 32'h0; SIZE = 2'd2; WD = 32'h1234_5678;
      @(posedge clk); #1;
      check("mid.busy", {31'd0, busy}, 32'd1);
    end
    reset = 1'b1; #1;
    check("mid.rst_busy", {31'd0, busy}, 32'd1);
    check("mid.rst_flt", {31'd0, fault_sticky}, 32'd0);
    reset = 1'b0;
    wait_clear("reclr", 1'b1);
    for (int w = 0; w < DEPTH; w++) op("zero2", 1'b0, 32'(4 * w), 2'd2, 1'b0, 32'd0);
    op("fin_st", 1'b1, 32'h4, 2'd1, 1'b1, 32'h0000_8001);
    op("fin_ld", 1'b0, 32'h4, 2'd1, 1'b1, 32'd0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
`default_nettype wire
